lcd_spi_rx: RTL
===============

# lcd_spi_rx

Receive-side decoder for the 4-wire serial LCD link that our display driver emits (SCK, CS, D/C, SDA; MSB first; 8-bit command/data bytes; RGB565 pixels as two data bytes). It runs on the system clock, oversamples the link, and decodes the ST7789-style stream into command strobes, a tracked column/row window, and per-pixel write strobes with (x, y, data). It serves as a panel model for on-FPGA loopback of the driver and as the input stage for a framebuffer sink.

## Interface
Parameters:
- H_RES, 240: default column-end value (XE resets to H_RES-1).
- V_RES, 320: default row-end value (YE resets to V_RES-1).

Ports:
- clk  in  1  system clock; must be at least 4× the SCK frequency.
- resetn  in  1  reset, asynchronous, active-low.
- lcd_clk  in  1  serial clock; data is sampled on its rising edge.
- lcd_cs  in  1  chip select, active-low.
- lcd_rs  in  1  D/C: 0 = command byte, 1 = data byte.
- lcd_data  in  1  serial data, MSB first.
- cmd_valid  out  1  one-cycle strobe; a command byte completed.
- cmd_byte  out  8  last command opcode; held until the next command.
- pix_valid  out  1  one-cycle strobe; a pixel completed.
- pix_x, pix_y  out  16  pixel coordinates, valid with pix_valid.
- pix_data  out  16  RGB565 pixel, valid with pix_valid.
- frame_done  out  1  one-cycle strobe, coincident with the pix_valid for (XE, YE).
- sleep_out  out  1  1 after 0x11 (exit sleep), 0 after 0x10.
- disp_on  out  1  1 after 0x29, 0 after 0x28.
- madctl, colmod  out  8  first parameter byte received after 0x36 and 0x3A respectively.
- byte_err  out  1  one-cycle strobe; CS rose while a byte was incomplete.

## Operation
- Synchronizers: each of lcd_clk, lcd_cs, lcd_rs and lcd_data passes through a 2-flop synchronizer. An SCK rising edge is detected when the synced SCK is 1 and its previous value was 0.
- Bit capture: on a detected edge with synced CS = 0, shift synced SDA into an 8-bit register and increment bit_cnt (0..7). On the 8th bit:
  - Byte complete; its type comes from D/C as sampled with that bit.
  - bit_cnt returns to 0.
- CS high:
  - bit_cnt clears. If bit_cnt ≠ 0, pulse byte_err and discard the partial byte.
  - Decoder state, the parameter index and a half-received pixel are all preserved. The driver toggles CS per byte, so a CS toggle must not reset the decoder.
- Decoder FSM states: IDLE, CASET, RASET, RAMWR, PARAM1, SKIP.
- A command byte is accepted in any state. It pulses cmd_valid, loads cmd_byte, clears param_idx and the pixel half flag, then:
  - 0x2A → CASET.
  - 0x2B → RASET.
  - 0x2C → RAMWR, with x←XS and y←YS.
  - 0x36, 0x3A → PARAM1.
  - 0x11, 0x10, 0x29, 0x28 → update the corresponding flag, then IDLE.
  - Any other opcode → SKIP.
- Data bytes:
  - IDLE and SKIP: ignored.
  - PARAM1: write madctl or colmod (according to cmd_byte), then SKIP.
  - CASET: param_idx 0..3 writes XS[15:8], XS[7:0], XE[15:8], XE[7:0]. Bytes with param_idx > 3 are ignored, and param_idx saturates at 4.
  - RASET: same as CASET, writing YS and YE.
  - RAMWR, half = 0: store the byte as the high byte and set half.
  - RAMWR, half = 1: pulse pix_valid with pix_data = {hi, byte} at the current (x, y), then clear half.
- Pixel address advance (16-bit arithmetic):
  - If x ≥ XE: x←XS, and y←YS if y ≥ YE, else y←y+1.
  - Otherwise: x←x+1.
  - frame_done pulses when x ≥ XE and y ≥ YE at the time of the pixel write.
  - The ≥ comparison makes a window with XS > XE or YS > YE degenerate to a single column or row; no lock-up.
- Window changes (CASET/RASET) while in RAMWR take effect only at the next 0x2C.

## Timing
- Reset values:
  - All strobes, sleep_out and disp_on: 0.
  - cmd_byte, madctl, colmod, pix_*: 0.
  - XS = YS = 0, XE = H_RES-1, YE = V_RES-1.
  - FSM = IDLE, bit_cnt = 0, half = 0; synchronizers cleared to 0 except CS, which clears to 1.
- Latency: the 8th-bit SCK rising edge at the pin produces cmd_valid or pix_valid exactly 4 clk cycles later (2 sync + 1 edge detect + 1 decode register).
- Required input timing:
  - SCK high and low phases ≥ 2 clk each.
  - SDA and D/C stable ≥ 1 clk before and after each SCK rising edge.
  - CS fall ≥ 2 clk before the first SCK rise.
- Strobes are exactly one cycle wide. pix_valid and frame_done may coincide; cmd_valid and pix_valid never do.
- An asynchronous reset mid-byte or mid-frame returns every register to its reset value immediately, with no strobe.

## Test plan
- Send 0x11, then 0x29 (CS toggled per byte) → two cmd_valid pulses with cmd_byte 0x11 then 0x29; sleep_out = 1 and disp_on = 1; each strobe 4 clk after the last SCK rise.
- Send 0x2A 00 28 01 17, then 0x2B 00 35 00 BB → XS = 0x0028, XE = 0x0117, YS = 0x0035, YE = 0x00BB.
- Set the window to x 2..3, y 5..6, send 0x2C, then 5 pixels 0xF800 → pix (2,5), (3,5), (2,6), (3,6) with frame_done on the 4th, then (2,5); pix_data = 0xF800 on all five.
- Raise CS after 5 bits of a data byte during RAMWR → byte_err pulse; no pix_valid; the next complete byte continues the pixel stream unchanged.
- Send 0x3A 05 AA → colmod = 0x05; byte 0xAA ignored. Then send 0x36 70 → madctl = 0x70.
- Assert resetn low mid-pixel, then release it and send one pixel without 0x2C → no pix_valid (FSM in IDLE); all outputs at their reset values.

Source files
------------

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx - receive-side decoder for the 4-wire serial LCD link.
//
// Oversamples SCK/CS/DC/SDA on clk, assembles MSB-first bytes, and decodes
// the ST7789-style command stream. Its outputs are command strobes, the
// tracked column/row window, and per-pixel write strobes carrying (x, y,
// RGB565). CS is toggled by the driver around every byte. Because of that,
// CS only aborts a partial byte and never resets the decoder.
//
// Ports
//   clk, resetn          system clock (>= 4x SCK), async active-low reset
//   lcd_clk/cs/rs/data   serial link pins (SCK, CS_n, D/C, SDA)
//   cmd_valid, cmd_byte  command strobe and last opcode
//   pix_valid, pix_x/y   pixel strobe and coordinates
//   pix_data             RGB565 pixel value
//   frame_done           strobe on the pixel written at (XE, YE)
//   sleep_out, disp_on   panel power/display flags
//   madctl, colmod       first parameter of 0x36 / 0x3A
//   byte_err             strobe when CS rose with a byte incomplete
//
// state  | meaning
// IDLE   | no command open, data bytes ignored
// CASET  | collecting XS/XE parameter bytes
// RASET  | collecting YS/YE parameter bytes
// RAMWR  | pixel stream, two data bytes per pixel
// PARAM1 | next data byte loads madctl or colmod
// SKIP   | unsupported command or surplus parameters, data ignored

module lcd_spi_rx #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lcd_clk,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic        sleep_out,
    output logic        disp_on,
    output logic [7:0]  madctl,
    output logic [7:0]  colmod,
    output logic        byte_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_PARAM1,
        ST_SKIP
    } state_t;

    logic [1:0]  sck_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  rs_sync;
    logic [1:0]  sda_sync;
    logic        sck_prev;
    logic        sck_rise;
    logic        cs_d;
    logic        rs_d;
    logic        sda_d;

    logic [6:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_byte;
    state_t      state;
    logic [2:0]  param_idx;
    logic        half;
    logic [7:0]  pix_hi;
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
    logic [15:0] x;
    logic [15:0] y;
    logic        x_end;
    logic        y_end;

    // The byte completes on the 8th bit. Its last bit is taken straight from
    // the pipeline and is not shifted in first.
    assign rx_byte = {shreg, sda_d};
    // >= rather than == so an inverted window degenerates instead of running away
    assign x_end   = (x >= xe);
    assign y_end   = (y >= ye);

    // Two-flop synchronizers followed by one registered edge-detect stage.
    // SDA, D/C and CS are delayed alongside so they stay aligned with sck_rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync <= 2'b00;
            cs_sync  <= 2'b11;
            rs_sync  <= 2'b00;
            sda_sync <= 2'b00;
            sck_prev <= 1'b0;
            sck_rise <= 1'b0;
            cs_d     <= 1'b1;
            rs_d     <= 1'b0;
            sda_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], lcd_clk};
            cs_sync  <= {cs_sync[0], lcd_cs};
            rs_sync  <= {rs_sync[0], lcd_rs};
            sda_sync <= {sda_sync[0], lcd_data};
            sck_prev <= sck_sync[1];
            sck_rise <= sck_sync[1] & ~sck_prev;
            cs_d     <= cs_sync[1];
            rs_d     <= rs_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            state      <= ST_IDLE;
            param_idx  <= '0;
            half       <= 1'b0;
            pix_hi     <= '0;
            xs         <= '0;
            xe         <= 16'(H_RES - 1);
            ys         <= '0;
            ye         <= 16'(V_RES - 1);
            x          <= '0;
            y          <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            sleep_out  <= 1'b0;
            disp_on    <= 1'b0;
            madctl     <= '0;
            colmod     <= '0;
            byte_err   <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            byte_err   <= 1'b0;

            if (cs_d) begin
                // Only the partial byte is dropped. State, param_idx and half survive.
                if (bit_cnt != 3'd0) begin
                    byte_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shreg <= rx_byte[6:0];
                if (bit_cnt != 3'd7) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    bit_cnt <= '0;
                    if (!rs_d) begin
                        cmd_valid <= 1'b1;
                        cmd_byte  <= rx_byte;
                        param_idx <= '0;
                        half      <= 1'b0;
                        case (rx_byte)
                            8'h2A: state <= ST_CASET;
                            8'h2B: state <= ST_RASET;
                            8'h2C: begin
                                state <= ST_RAMWR;
                                x     <= xs;
                                y     <= ys;
                            end
                            8'h36, 8'h3A: state <= ST_PARAM1;
                            8'h11: begin
                                sleep_out <= 1'b1;
                                state     <= ST_IDLE;
                            end
                            8'h10: begin
                                sleep_out <= 1'b0;
                                state     <= ST_IDLE;
                            end
                            8'h29: begin
                                disp_on <= 1'b1;
                                state   <= ST_IDLE;
                            end
                            8'h28: begin
                                disp_on <= 1'b0;
                                state   <= ST_IDLE;
                            end
                            default: state <= ST_SKIP;
                        endcase
                    end else begin
                        case (state)
                            ST_PARAM1: begin
                                if (cmd_byte == 8'h36) begin
                                    madctl <= rx_byte;
                                end else begin
                                    colmod <= rx_byte;
                                end
                                state <= ST_SKIP;
                            end
                            ST_CASET, ST_RASET: begin
                                if (param_idx < 3'd4) begin
                                    param_idx <= param_idx + 3'd1;
                                end
                                case (param_idx)
                                    3'd0: begin
                                        if (state == ST_CASET) xs[15:8] <= rx_byte;
                                        else                   ys[15:8] <= rx_byte;
                                    end
                                    3'd1: begin
                                        if (state == ST_CASET) xs[7:0] <= rx_byte;
                                        else                   ys[7:0] <= rx_byte;
                                    end
                                    3'd2: begin
                                        if (state == ST_CASET) xe[15:8] <= rx_byte;
                                        else                   ye[15:8] <= rx_byte;
                                    end
                                    3'd3: begin
                                        if (state == ST_CASET) xe[7:0] <= rx_byte;
                                        else                   ye[7:0] <= rx_byte;
                                    end
                                    default: ;
                                endcase
                            end
                            ST_RAMWR: begin
                                if (!half) begin
                                    pix_hi <= rx_byte;
                                    half   <= 1'b1;
                                end else begin
                                    half       <= 1'b0;
                                    pix_valid  <= 1'b1;
                                    pix_data   <= {pix_hi, rx_byte};
                                    pix_x      <= x;
                                    pix_y      <= y;
                                    frame_done <= x_end & y_end;
                                    if (x_end) begin
                                        x <= xs;
                                        y <= y_end ? ys : y + 16'd1;
                                    end else begin
                                        x <= x + 16'd1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule
